// File: rtl/hdmi_probe_pkg.sv
// hdmi_probe_pkg
//   Shared constants for the multi-point HDMI pixel probe.
//   Holds the Wishbone register map (region/sel decode values), the CTRL
//   register bit positions, and the state type of the one-shot arm sequencer.
//   No ports; imported by hdmi_pixel_probe and hdmi_probe_chan.
package hdmi_probe_pkg;

  // Address decode values. The bus address is {region, probe, sel}.
  localparam logic REGION_CTRL  = 1'b0;
  localparam logic REGION_PROBE = 1'b1;

  localparam logic SEL_CTRL = 1'b0;  // region 0
  localparam logic SEL_FLEN = 1'b1;  // region 0
  localparam logic SEL_TGT  = 1'b0;  // region 1
  localparam logic SEL_PIX  = 1'b1;  // region 1

  // CTRL register layout.
  localparam int CTRL_MODE_BIT  = 0;   // W/R: 1 = continuous capture
  localparam int CTRL_ARM_BIT   = 1;   // W: arm one-shot (self-clearing)
  localparam int CTRL_ARMED_BIT = 1;   // R: one-shot sequence in progress
  localparam int CTRL_VALID_LSB = 16;  // R: per-probe valid flags
  localparam int CTRL_OVF_BIT   = 30;  // R: pixel counter saturated
  localparam int CTRL_LENV_BIT  = 31;  // R: frame length measured

  // PIX[k] layout: valid flag in the top bit, capture word at the bottom.
  localparam int PIX_VALID_BIT = 31;

  // One-shot arm sequencer.
  typedef enum logic [1:0] {
    ARM_IDLE     = 2'd0,
    ARM_WAIT_SOF = 2'd1,
    ARM_ACTIVE   = 2'd2
  } arm_state_t;

endpackage

// File: rtl/hdmi_probe_chan.sv
// hdmi_probe_chan
//   One probe of the pixel sampler: a target-index register, the index
//   comparator, the captured pixel word and its valid flag.
// Ports
//   clk        in   1        clock (shared bus/pixel clock)
//   reset      in   1        synchronous active-high reset
//   tgt_we     in   1        load tgt_wdata into the target register
//   tgt_wdata  in   CLKBITS  new target index
//   arm_clear  in   1        ARM request: clear valid, suppress capture
//   cap_en     in   1        capture permitted on this pixel
//   pix_live   in   1        valid pixel seen while the stream is synced
//   pix_index  in   CLKBITS  index of the current pixel in its frame
//   pix_data   in   PW       current pixel word
//   tgt        out  CLKBITS  target register
//   capture    out  PW       last captured pixel word
//   valid      out  1        capture holds a pixel since the last ARM/reset
//   hit        out  1        this pixel is being captured this cycle
module hdmi_probe_chan
  import hdmi_probe_pkg::*;
#(
  parameter int PW      = 30,
  parameter int CLKBITS = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tgt_we,
  input  logic [CLKBITS-1:0] tgt_wdata,
  input  logic               arm_clear,
  input  logic               cap_en,
  input  logic               pix_live,
  input  logic [CLKBITS-1:0] pix_index,
  input  logic [PW-1:0]      pix_data,
  output logic [CLKBITS-1:0] tgt,
  output logic [PW-1:0]      capture,
  output logic               valid,
  output logic               hit
);

  logic match;

  // The comparator sees the register value before any write landing this
  // cycle, so retargeting mid-frame still catches the old index once.
  assign match = pix_live && (pix_index == tgt);

  // An ARM in the same cycle takes priority over a capture.
  assign hit = match && cap_en && !arm_clear;

  // Target register, written from the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt <= '0;
    end else if (tgt_we) begin
      tgt <= tgt_wdata;
    end
  end

  // Capture register and valid flag. valid is sticky: only ARM or reset
  // clears it, so continuous mode keeps it set across frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture <= '0;
      valid   <= 1'b0;
    end else if (arm_clear) begin
      valid <= 1'b0;
    end else if (hit) begin
      capture <= pix_data;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_pixel_probe.sv
// hdmi_pixel_probe
//   Wishbone-controlled multi-point pixel sampler. NPROBES probes each grab
//   the pixel at a programmable index within the frame, either once per ARM
//   (one-shot, first full frame only) or on every frame (continuous). The
//   frame length is measured from the stream rather than programmed.
// Ports
//   i_clk        in   1        single clock (bus and pixel stream)
//   i_reset      in   1        synchronous active-high reset
//   i_pix_valid  in   1        pixel strobe
//   i_pix_sof    in   1        start of frame, qualified by i_pix_valid
//   i_pix_data   in   PW       pixel word
//   i_wb_cyc     in   1        Wishbone cycle
//   i_wb_stb     in   1        Wishbone strobe
//   i_wb_we      in   1        Wishbone write enable
//   i_wb_addr    in   LGN+2    {region, probe, sel}
//   i_wb_data    in   32       Wishbone write data
//   o_wb_ack     out  1        ack, one cycle after the strobe
//   o_wb_stall   out  1        always 0
//   o_wb_data    out  32       registered read data
module hdmi_pixel_probe
  import hdmi_probe_pkg::*;
#(
  parameter int LGN     = 2,
  parameter int PW      = 30,
  parameter int CLKBITS = 30
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pix_valid,
  input  logic             i_pix_sof,
  input  logic [PW-1:0]    i_pix_data,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [LGN+1:0]   i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [31:0]      o_wb_data
);

  localparam int NPROBES = 1 << LGN;
  localparam logic [CLKBITS-1:0] CNT_MAX  = '1;
  localparam logic [CLKBITS-1:0] CNT_ONE  = CLKBITS'(1);
  localparam logic [CLKBITS-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  // Bus decode
  logic               addr_region;
  logic               addr_sel;
  logic [LGN-1:0]     addr_probe;
  logic               wb_write;
  logic               ctrl_write;
  logic               tgt_write;
  logic               arm_req;
  logic               unused_wb_bits;

  // Stream tracking
  logic               sof_pix;
  logic               pix_live;
  logic [CLKBITS-1:0] counter;
  logic [CLKBITS-1:0] pix_index;
  logic               synced;
  logic               overflow;
  logic [CLKBITS-1:0] frame_len;
  logic               len_valid;

  // Control and probes
  logic               mode;
  arm_state_t         arm_state;
  arm_state_t         arm_next;
  logic               oneshot_win;
  logic               cap_en;
  logic               all_done;
  logic [CLKBITS-1:0] tgt     [NPROBES];
  logic [PW-1:0]      capture [NPROBES];
  logic [NPROBES-1:0] valid;
  logic [NPROBES-1:0] hit;
  logic [31:0]        rdata;

  assign addr_region = i_wb_addr[LGN+1];
  assign addr_probe  = i_wb_addr[LGN:1];
  assign addr_sel    = i_wb_addr[0];

  assign wb_write   = i_wb_cyc && i_wb_stb && i_wb_we;
  assign ctrl_write = wb_write && (addr_region == REGION_CTRL) && (addr_sel == SEL_CTRL);
  assign tgt_write  = wb_write && (addr_region == REGION_PROBE) && (addr_sel == SEL_TGT);
  assign arm_req    = ctrl_write && i_wb_data[CTRL_ARM_BIT];

  // Only a few write-data bits reach registers; the rest are don't-care.
  assign unused_wb_bits = &{1'b0, i_wb_data};

  assign o_wb_stall = 1'b0;

  // The sof pixel itself is index 0 and already counts as synced, so a probe
  // targeting index 0 can capture the very pixel that establishes sync.
  assign sof_pix   = i_pix_valid && i_pix_sof;
  assign pix_live  = i_pix_valid && (synced || i_pix_sof);
  assign pix_index = i_pix_sof ? '0 : counter;

  // Capture mode register; ARM is a pulse and is not stored here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode <= 1'b0;
    end else if (ctrl_write) begin
      mode <= i_wb_data[CTRL_MODE_BIT];
    end
  end

  // Pixel counter, sync and frame-length measurement. After the sof pixel
  // the counter holds the index of the next pixel, so at the following sof
  // it equals the number of pixels in the frame just finished. The counter
  // saturates rather than wrapping so an oversized frame cannot alias onto
  // small target indices.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      counter   <= '0;
      synced    <= 1'b0;
      overflow  <= 1'b0;
      frame_len <= '0;
      len_valid <= 1'b0;
    end else if (i_pix_valid) begin
      if (i_pix_sof) begin
        counter <= CNT_ONE;
        synced  <= 1'b1;
        if (synced) begin
          frame_len <= counter;
          len_valid <= 1'b1;
        end
      end else if (counter != CNT_MAX) begin
        counter <= counter + CNT_ONE;
        if (counter == CNT_LAST) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // One-shot window: the sof pixel that starts the first full frame after
  // ARM, then every pixel up to (not including) the next sof.
  assign oneshot_win = ((arm_state == ARM_WAIT_SOF) && sof_pix) ||
                       ((arm_state == ARM_ACTIVE) && !sof_pix);
  assign cap_en      = mode || oneshot_win;
  assign all_done    = &(valid | hit);

  for (genvar k = 0; k < NPROBES; k++) begin : g_chan
    hdmi_probe_chan #(
      .PW      (PW),
      .CLKBITS (CLKBITS)
    ) u_chan (
      .clk       (i_clk),
      .reset     (i_reset),
      .tgt_we    (tgt_write && (addr_probe == LGN'(k))),
      .tgt_wdata (i_wb_data[CLKBITS-1:0]),
      .arm_clear (arm_req),
      .cap_en    (cap_en),
      .pix_live  (pix_live),
      .pix_index (pix_index),
      .pix_data  (i_pix_data),
      .tgt       (tgt[k]),
      .capture   (capture[k]),
      .valid     (valid[k]),
      .hit       (hit[k])
    );
  end

  // Arm sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      arm_state <= ARM_IDLE;
    end else begin
      arm_state <= arm_next;
    end
  end

  // Arm sequencer next state. Finishing early once every probe holds a
  // pixel lets software see completion without waiting for the next frame.
  // A fresh ARM always restarts the sequence, whatever else happens.
  always_comb begin
    arm_next = arm_state;
    case (arm_state)
      ARM_IDLE: begin
        arm_next = ARM_IDLE;
      end
      ARM_WAIT_SOF: begin
        if (all_done) begin
          arm_next = ARM_IDLE;
        end else if (sof_pix) begin
          arm_next = ARM_ACTIVE;
        end
      end
      ARM_ACTIVE: begin
        if (sof_pix || all_done) begin
          arm_next = ARM_IDLE;
        end
      end
      default: begin
        arm_next = ARM_IDLE;
      end
    endcase
    if (arm_req) begin
      arm_next = ARM_WAIT_SOF;
    end
  end

  // Read mux.
  always_comb begin
    rdata = '0;
    if (addr_region == REGION_CTRL) begin
      if (addr_sel == SEL_CTRL) begin
        rdata[CTRL_MODE_BIT]                = mode;
        rdata[CTRL_ARMED_BIT]               = (arm_state != ARM_IDLE);
        rdata[CTRL_VALID_LSB +: NPROBES]    = valid;
        rdata[CTRL_OVF_BIT]                 = overflow;
        rdata[CTRL_LENV_BIT]                = len_valid;
      end else begin
        rdata[CLKBITS-1:0] = frame_len;
      end
    end else begin
      if (addr_sel == SEL_TGT) begin
        rdata[CLKBITS-1:0] = tgt[addr_probe];
      end else begin
        rdata[PW-1:0]        = capture[addr_probe];
        rdata[PIX_VALID_BIT] = valid[addr_probe];
      end
    end
  end

  // Bus response: ack every strobe one cycle later, read data registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= i_wb_stb;
      if (i_wb_stb) begin
        o_wb_data <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_probe.sv
// tb_hdmi_pixel_probe
//   Directed bench for hdmi_pixel_probe. A frame-level reference model tracks
//   what every register must read; a compare process checks ack and read data
//   each cycle, and literal expectations pin key results. A second instance
//   with a 4-bit counter covers saturation.
module tb_hdmi_pixel_probe;

  localparam int NP = 4;
  localparam longint MAXC = (64'd1 << 30) - 1;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pix_valid = 1'b0;
  logic        i_pix_sof = 1'b0;
  logic [29:0] i_pix_data = '0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [3:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  logic        b4_stb = 1'b0;
  logic        b4_we = 1'b0;
  logic [3:0]  b4_addr = '0;
  logic [31:0] b4_wdata = '0;
  logic        b4_ack;
  logic        b4_stall;
  logic [31:0] b4_data;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  always #5 i_clk = ~i_clk;

  hdmi_pixel_probe #(.LGN(2), .PW(30), .CLKBITS(30)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pix_valid(i_pix_valid), .i_pix_sof(i_pix_sof), .i_pix_data(i_pix_data),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data)
  );

  hdmi_pixel_probe #(.LGN(2), .PW(30), .CLKBITS(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pix_valid(i_pix_valid), .i_pix_sof(i_pix_sof), .i_pix_data(i_pix_data),
    .i_wb_cyc(b4_stb), .i_wb_stb(b4_stb), .i_wb_we(b4_we),
    .i_wb_addr(b4_addr), .i_wb_data(b4_wdata),
    .o_wb_ack(b4_ack), .o_wb_stall(b4_stall), .o_wb_data(b4_data)
  );

  // ---------------- reference model ----------------
  // Counter state is kept as "pixels since the last sof", clamped; the
  // one-shot window is tracked as the number of sofs seen since ARM.
  bit          m_mode, m_armed, m_synced, m_ovf, m_lenv;
  int          m_frames;
  longint      m_n, m_flen;
  logic [29:0] m_tgt [NP];
  logic [29:0] m_cap [NP];
  bit          m_valid [NP];
  logic        exp_ack = 1'b0;
  logic [31:0] exp_data = '0;

  task automatic modelReset();
    m_mode = 0; m_armed = 0; m_synced = 0; m_ovf = 0; m_lenv = 0;
    m_frames = 0; m_n = 0; m_flen = 0;
    for (int k = 0; k < NP; k++) begin
      m_tgt[k] = '0; m_cap[k] = '0; m_valid[k] = 0;
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    logic [31:0] r;
    int k;
    r = '0;
    k = int'(a[2:1]);
    if (!a[3] && !a[0]) begin
      r[0] = m_mode;
      r[1] = m_armed;
      for (int j = 0; j < NP; j++) r[16 + j] = m_valid[j];
      r[30] = m_ovf;
      r[31] = m_lenv;
    end else if (!a[3]) begin
      r = 32'(m_flen);
    end else if (!a[0]) begin
      r = {2'b00, m_tgt[k]};
    end else begin
      r = {m_valid[k], 1'b0, m_cap[k]};
    end
    return r;
  endfunction

  task automatic modelPixel(input bit sof, input logic [29:0] d, input bit arm);
    longint idx;
    bit live, all;
    live = m_synced || sof;
    idx = sof ? 0 : m_n;
    if (sof) begin
      if (m_synced) begin m_flen = m_n; m_lenv = 1; end
      if (m_armed) begin
        m_frames++;
        if (m_frames >= 1) m_armed = 0;
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (live && !arm && idx == longint'(m_tgt[k]) &&
          (m_mode || (m_armed && m_frames == 0))) begin
        m_cap[k] = d;
        m_valid[k] = 1;
      end
    end
    all = 1;
    for (int k = 0; k < NP; k++) all = all && m_valid[k];
    if (m_armed && all) m_armed = 0;
    if (sof) begin
      m_n = 1; m_synced = 1;
    end else if (m_n < MAXC) begin
      m_n++;
      if (m_n == MAXC) m_ovf = 1;
    end
  endtask

  task automatic modelWrite(input logic [3:0] a, input logic [31:0] d);
    if (!a[3] && !a[0]) begin
      m_mode = d[0];
      if (d[1]) begin
        m_armed = 1; m_frames = -1;
        for (int k = 0; k < NP; k++) m_valid[k] = 0;
      end
    end else if (a[3] && !a[0]) begin
      m_tgt[int'(a[2:1])] = d[29:0];
    end
  endtask

  // Model advances on the same edges as the design, using pre-edge state
  // for the read data and the pixel match, then applying the bus write.
  always @(posedge i_clk) begin
    bit arm_now;
    if (i_reset) begin
      modelReset();
      exp_ack = 1'b0;
      exp_data = '0;
    end else begin
      if (i_wb_stb) exp_data = modelRead(i_wb_addr);
      exp_ack = i_wb_stb;
      arm_now = i_wb_stb && i_wb_we && (i_wb_addr == 4'd0) && i_wb_data[1];
      if (i_pix_valid) modelPixel(i_pix_sof, i_pix_data, arm_now);
      if (i_wb_stb && i_wb_we) modelWrite(i_wb_addr, i_wb_data);
    end
  end

  // Compare process: ack every cycle, read data whenever acked.
  always @(negedge i_clk) begin
    if (checking) begin
      vectors++;
      if (o_wb_ack !== exp_ack) begin
        miscompares++;
        $display("[TB] FAIL ack @%0t: got %b expected %b", $time, o_wb_ack, exp_ack);
      end
      if (exp_ack) begin
        vectors++;
        if (o_wb_data !== exp_data) begin
          miscompares++;
          $display("[TB] FAIL rdata @%0t: got %h expected %h", $time, o_wb_data, exp_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic pv, input logic ps, input logic [29:0] pd,
                               input logic stb, input logic we, input logic [3:0] addr,
                               input logic [31:0] wd);
    i_pix_valid = pv; i_pix_sof = ps; i_pix_data = pd;
    i_wb_cyc = stb; i_wb_stb = stb; i_wb_we = we; i_wb_addr = addr; i_wb_data = wd;
    @(posedge i_clk);
    #1;
    i_pix_valid = 0; i_pix_sof = 0;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(0, 0, '0, 1, 1, a, d);
  endtask

  task automatic readCheck(input string name, input logic [3:0] a, input logic [31:0] exp);
    applyStimulus(0, 0, '0, 1, 0, a, '0);
    checkOutput(name, o_wb_data, exp);
  endtask

  task automatic bus4(input logic we, input logic [3:0] a, input logic [31:0] d);
    b4_stb = 1; b4_we = we; b4_addr = a; b4_wdata = d;
    @(posedge i_clk);
    #1;
    b4_stb = 0; b4_we = 0;
  endtask

  task automatic readCheck4(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus4(0, a, '0);
    checkOutput(name, b4_data, exp);
  endtask

  // Pixels first..last of frame f, data = f<<8 | index; optional bus write
  // riding on the pixel at hookIdx.
  task automatic runPixels(input int f, input int first, input int last, input int hookIdx,
                           input logic [3:0] ha, input logic [31:0] hd);
    for (int i = first; i <= last; i++) begin
      logic [29:0] d;
      d = 30'((f << 8) | i);
      if (i == hookIdx) applyStimulus(1, i == 0, d, 1, 1, ha, hd);
      else              applyStimulus(1, i == 0, d, 0, 0, '0, '0);
    end
  endtask

  task automatic runFrame(input int f, input int len);
    runPixels(f, 0, len - 1, -1, '0, '0);
    applyStimulus(0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic doReset();
    i_reset = 1;
    repeat (3) applyStimulus(0, 0, '0, 0, 0, '0, '0);
    i_reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    applyStimulus(0, 0, '0, 0, 0, '0, '0);
    checking = 1'b1;
    // Read strobe while held in reset: no ack, data 0.
    applyStimulus(0, 0, '0, 1, 0, 4'd0, '0);
    checkOutput("ack_during_reset", {31'd0, o_wb_ack}, 32'd0);
    doReset();
    readCheck("rst_ctrl", 4'd0, 32'h0);
    readCheck("rst_flen", 4'd1, 32'h0);
    readCheck("rst_pix0", 4'd9, 32'h0);
    readCheck("rst_tgt3", 4'd14, 32'h0);

    $display("[TB] one-shot capture of indices 0,5,99,150");
    busWrite(4'd8, 32'd0);
    busWrite(4'd10, 32'd5);
    busWrite(4'd12, 32'd99);
    busWrite(4'd14, 32'd150);
    busWrite(4'd0, 32'h2);
    runFrame(1, 100);
    readCheck("t1_ctrl_armed", 4'd0, 32'h0007_0002);
    runFrame(2, 100);
    readCheck("t1_ctrl_done", 4'd0, 32'h8007_0000);
    readCheck("t1_pix0", 4'd9, 32'h8000_0100);
    readCheck("t1_pix1", 4'd11, 32'h8000_0105);
    readCheck("t1_pix2", 4'd13, 32'h8000_0163);
    readCheck("t1_pix3", 4'd15, 32'h0);
    readCheck("t1_flen", 4'd1, 32'd100);

    $display("[TB] continuous capture");
    doReset();
    busWrite(4'd0, 32'h1);
    busWrite(4'd10, 32'd7);
    runFrame(1, 100);
    readCheck("t2_pix1_f1", 4'd11, 32'h8000_0107);
    runFrame(2, 100);
    runFrame(3, 100);
    readCheck("t2_pix1_f3", 4'd11, 32'h8000_0307);
    readCheck("t2_flen", 4'd1, 32'd100);

    $display("[TB] ARM colliding with a match");
    doReset();
    busWrite(4'd0, 32'h1);
    busWrite(4'd8, 32'd5);
    runPixels(1, 0, 99, 5, 4'd0, 32'h3);
    readCheck("t3_ctrl_after_arm", 4'd0, 32'h0000_0003);
    readCheck("t3_pix0_none", 4'd9, 32'h0);
    runFrame(2, 100);
    readCheck("t3_pix0_next", 4'd9, 32'h8000_0205);
    readCheck("t3_ctrl_done", 4'd0, 32'h800F_0001);

    $display("[TB] retarget during the matching pixel");
    busWrite(4'd12, 32'd10);
    runPixels(3, 0, 15, 10, 4'd12, 32'd20);
    readCheck("t4_pix2_old_tgt", 4'd13, 32'h8000_030A);
    runPixels(3, 16, 99, -1, '0, '0);
    readCheck("t4_pix2_new_tgt", 4'd13, 32'h8000_0314);
    readCheck("t4_tgt2", 4'd12, 32'd20);
    runFrame(4, 100);
    readCheck("t4_pix2_f4", 4'd13, 32'h8000_0414);

    $display("[TB] 4-bit counter saturation");
    doReset();
    bus4(1, 4'd0, 32'h1);
    bus4(1, 4'd8, 32'd15);
    runFrame(1, 20);
    runFrame(2, 20);
    readCheck4("t5_ctrl", 4'd0, 32'hC00F_0001);
    readCheck4("t5_flen", 4'd1, 32'd15);
    readCheck4("t5_pix0_held", 4'd9, 32'h8000_0213);
    readCheck4("t5_tgt0", 4'd8, 32'd15);

    $display("[TB] reset in the middle of a frame");
    doReset();
    busWrite(4'd0, 32'h1);
    busWrite(4'd8, 32'd30);
    runPixels(1, 0, 40, -1, '0, '0);
    readCheck("t6_pix0_pre", 4'd9, 32'h8000_011E);
    i_reset = 1;
    applyStimulus(1, 0, 30'h129, 1, 0, 4'd9, '0);
    checkOutput("t6_ack_in_reset", {31'd0, o_wb_ack}, 32'd0);
    checkOutput("t6_data_in_reset", o_wb_data, 32'd0);
    i_reset = 0;
    readCheck("t6_ctrl", 4'd0, 32'h0);
    readCheck("t6_pix0", 4'd9, 32'h0);
    readCheck("t6_tgt0", 4'd8, 32'h0);
    busWrite(4'd0, 32'h1);
    busWrite(4'd8, 32'd50);
    runPixels(1, 42, 99, -1, '0, '0);
    readCheck("t6_pix0_unsynced", 4'd9, 32'h0);
    readCheck("t6_ctrl_unsynced", 4'd0, 32'h0000_0001);
    runFrame(2, 100);
    readCheck("t6_pix0_resync", 4'd9, 32'h8000_0232);
    readCheck("t6_ctrl_resync", 4'd0, 32'h000F_0001);

    applyStimulus(0, 0, '0, 0, 0, '0, '0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
